// File: rtl/data_sram_resp_if.sv
// rtl/data_sram_resp_if.sv - core data SRAM request/response bus
interface data_sram_resp_if;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  // Core side drives requests and samples the registered read data
  modport master (
    output sram_en,
    output sram_we,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata
  );

  // Responder side
  modport slave (
    input  sram_en,
    input  sram_we,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data SRAM responder: word RAM with byte strobes plus LED/switch/timer register block
// Optional macro: DATA_SRAM_TIMER_INT_EN adds timer compare, pending bit, INT_STATUS and drives timer_int.
module data_sram_resp #(
  parameter int          RAM_AW   = 14,
  parameter logic [15:0] REG_PAGE = 16'hbfaf,
  parameter logic        SIMU     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  data_sram_resp_if.slave       bus,
  input  logic [7:0]            switch,
  output logic [15:0]           led,
  output logic                  timer_int
);

  // Register word offsets (byte offset >> 2; addr[1:0] is ignored)
  localparam logic [13:0] OFF_LED    = 14'h0;
  localparam logic [13:0] OFF_SWITCH = 14'h1;
  localparam logic [13:0] OFF_TIMER  = 14'h2;
  localparam logic [13:0] OFF_CMP    = 14'h3;
  localparam logic [13:0] OFF_SIMU   = 14'h5;
`ifdef DATA_SRAM_TIMER_INT_EN
  localparam logic [13:0] OFF_INT    = 14'h4;
`endif

  logic              is_reg;
  logic [13:0]       reg_word;
  logic [RAM_AW-1:0] ram_idx;
  logic              rd_req;
  logic              wr_req;
  logic              reg_wr;
  logic              ram_wr;

  logic [31:0]       mem [0:(2**RAM_AW)-1];
  logic [31:0]       ram_q;

  logic [7:0]        sw_meta;
  logic [7:0]        sw_sync;
  logic [31:0]       timer;
  logic [31:0]       timer_cmp;
  logic [31:0]       reg_q;

  // Request decode: register page by upper half-word, RAM aliases on the upper bits
  assign is_reg   = (bus.sram_addr[31:16] == REG_PAGE);
  assign reg_word = bus.sram_addr[15:2];
  assign ram_idx  = bus.sram_addr[RAM_AW+1:2];
  assign rd_req   = bus.sram_en && (bus.sram_we == 4'h0);
  assign wr_req   = bus.sram_en && (bus.sram_we != 4'h0);
  // Registers only take full-word writes; partial strobes are dropped
  assign reg_wr   = wr_req && is_reg && (bus.sram_we == 4'hf);
  assign ram_wr   = wr_req && !is_reg;

  assign ram_q    = mem[ram_idx];

  // RAM byte-lane write; contents are not reset and a write during reset is suppressed
  always_ff @(posedge clk) begin
    if (!reset && ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.sram_we[i]) begin
          mem[ram_idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Two-flop synchronizer for the asynchronous board switches
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= 8'h00;
      sw_sync <= 8'h00;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

  // LED register
  always_ff @(posedge clk) begin
    if (reset) begin
      led <= 16'h0000;
    end else if (reg_wr && (reg_word == OFF_LED)) begin
      led <= bus.sram_wdata[15:0];
    end
  end

  // Free-running timer; a software load replaces that cycle's increment
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= 32'h0000_0000;
    end else if (reg_wr && (reg_word == OFF_TIMER)) begin
      timer <= bus.sram_wdata;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  // Timer compare value; stays writable even without the interrupt logic
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_cmp <= 32'hffff_ffff;
    end else if (reg_wr && (reg_word == OFF_CMP)) begin
      timer_cmp <= bus.sram_wdata;
    end
  end

`ifdef DATA_SRAM_TIMER_INT_EN
  logic timer_pend;
  logic timer_hit;
  logic pend_clr;

  // Compare uses the registered (old) CMP and TIMER values of this cycle
  assign timer_hit = (timer == timer_cmp);
  assign pend_clr  = reg_wr && (reg_word == OFF_INT) && bus.sram_wdata[0];

  // Pending bit: a match in the same cycle as a W1C keeps it set
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_pend <= 1'b0;
    end else if (timer_hit) begin
      timer_pend <= 1'b1;
    end else if (pend_clr) begin
      timer_pend <= 1'b0;
    end
  end

  assign timer_int = timer_pend;
`else
  assign timer_int = 1'b0;
`endif

  // Register read mux; unmapped offsets read as zero
  always_comb begin
    reg_q = 32'h0000_0000;
    case (reg_word)
      OFF_LED:    reg_q = {16'h0000, led};
      OFF_SWITCH: reg_q = {24'h000000, sw_sync};
      OFF_TIMER:  reg_q = timer;
      OFF_CMP:    reg_q = timer_cmp;
`ifdef DATA_SRAM_TIMER_INT_EN
      OFF_INT:    reg_q = {31'h0, timer_pend};
`endif
      OFF_SIMU:   reg_q = {31'h0, SIMU};
      default:    reg_q = 32'h0000_0000;
    endcase
  end

  // Registered read data: loads only on reads, otherwise holds the last value
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sram_rdata <= 32'h0000_0000;
    end else if (rd_req) begin
      bus.sram_rdata <= is_reg ? reg_q : ram_q;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.sram_addr[1:0]};

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder for the core's data SRAM port: accepts `en/we/addr/wdata` requests from the core and returns `rdata` one cycle later, as the core's memory stage expects. Decodes each request to either a word-addressed RAM array with byte write strobes or a small register block (LED, switch, free-running timer with compare interrupt, simulation flag). Sits outside `cpu_core` in the SoC top, wired directly to the core's `data_sram_*` pins; the optional timer interrupt feeds one bit of the core's `hard_int_in`.

## Interface
- `RAM_AW`, 14, RAM word-address width (2^RAM_AW words).
- `REG_PAGE`, 16'hbfaf, `addr[31:16]` value that selects the register block.
- `SIMU`, 1, value returned by SIMU_FLAG (1 = simulation, 0 = board).
- `clk` in 1: sole clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `sram_en` in 1: request valid this cycle.
- `sram_we` in 4: byte write strobes; nonzero = write, zero = read.
- `sram_addr` in 32: byte address; `addr[1:0]` ignored.
- `sram_wdata` in 32: write data, byte lane i = bits [8i+7:8i].
- `sram_rdata` out 32: read data, registered.
- `switch` in 8: board switches, asynchronous.
- `led` out 16: LED register.
- `timer_int` out 1: timer compare interrupt, level.

## Operation
- Decode: `addr[31:16]==REG_PAGE` → register block at offset `addr[15:0]`; otherwise RAM at word index `addr[RAM_AW+1:2]` (upper bits ignored, aliasing).
- RAM write: each lane with `we[i]=1` updated; other lanes keep content. RAM contents not reset.
- Register write: only when `we==4'hf`; partial-strobe register writes ignored. Unmapped offsets: writes ignored, reads 0.
- Registers:
  - 0x0000 LED, RW, bits [15:0], reset 0.
  - 0x0004 SWITCH, RO, `{24'b0, switch_sync}`; `switch` passes a 2-flop synchronizer, reset 0.
  - 0x0008 TIMER, RW, 32-bit, +1 every cycle, wraps 0xFFFF_FFFF→0; reset 0; write loads wdata (no increment that cycle).
  - 0x000C TIMER_CMP, RW, reset 0xFFFF_FFFF.
  - 0x0010 INT_STATUS, bit0 = timer pending, write-1-to-clear, other bits read 0 (macro only).
  - 0x0014 SIMU_FLAG, RO, `{31'b0, SIMU}`.
- Read: `en && we==0` → `rdata` loaded at next edge with RAM word or register value sampled in the request cycle (TIMER returns pre-increment value).
- Write cycle or `en=0`: `rdata` holds previous value.
- Back-to-back: write to X at cycle n, read X at n+1 → returns new data.

## Timing
- Read latency exactly 1 cycle; no stall, no backpressure; one request accepted every cycle.
- Reset values: `rdata`=0, `led`=0, `timer_int`=0, TIMER=0, TIMER_CMP=0xFFFF_FFFF, pending=0, synchronizer=0.
- Reset asserted mid-stream: request in that cycle discarded; RAM write in that cycle suppressed.
- Timer pending set at edge after cycle where TIMER==TIMER_CMP; `timer_int` = pending register (1-cycle after match).
- Set and W1C clear in the same cycle: set wins.
- Write to TIMER_CMP equal to current TIMER in the same cycle: compare uses old CMP.

## Configuration
- `DATA_SRAM_TIMER_INT_EN` defined: compare logic, pending bit, INT_STATUS register present; `timer_int` driven as above.
- Not defined: no compare/pending logic; offset 0x0010 unmapped (reads 0, writes ignored); `timer_int` tied 0; TIMER and TIMER_CMP remain RW.

## Test plan
- Write 0xA5A5_A5A5 we=4'hf to 0x0000_0100, then we=4'b0010 wdata 0x0000_3C00, read → 0xA5A5_3CA5 one cycle after read request.
- After reset read 0xbfaf_0008 at cycle 10 after reset release → rdata equals 10 (±fixed offset documented by bench), next read 5 cycles later → +5; write 0xFFFF_FFFE then read twice consecutively → 0xFFFF_FFFF, 0x0000_0000.
- Write LED 0x1234 → `led`=0x1234 next cycle; partial write we=4'h1 to LED → `led` unchanged.
- `switch`=0x5A → SWITCH read returns 0x5A after 2-cycle sync; read 0xbfaf_0014 → 1 with SIMU=1; read 0xbfaf_0020 → 0.
- Macro on: CMP=100, TIMER=90 → `timer_int` rises 11 cycles later; write 1 to INT_STATUS → falls next cycle; macro off: `timer_int` stays 0.
- Assert reset during write to RAM 0x200 → content unchanged on later read, `rdata`=0 during reset.
